// File: rtl/alu_result_demux.sv
// alu_result_demux: registered 1:2 router for the ALU result stream.
// Each accepted word lands in the holding register of the destination picked
// by in_sel (0 = writeback path, 1 = store-data path). Each destination has
// its own slot, so a stall on one never blocks or corrupts the other.
// in_ready is the only output with a combinational path from the inputs.
// Optional feature: define ALU_RESULT_DEMUX_CNT_EN to build saturating
// per-destination drain counters on cnt0/cnt1; otherwise both are tied to 0.
module alu_result_demux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             proto_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             sel_valid;
    logic             sel_ready;
    logic             accept;
    logic             acc0;
    logic             acc1;
    logic             drain0;
    logic             drain1;
    logic             stall;
    logic             stall_q;
    logic [WIDTH-1:0] stall_data_q;
    logic             stall_sel_q;
    logic             violation;

    // Ready looks only at the slot the current word is headed for.
    always_comb begin
        sel_valid = in_sel ? out1_valid : out0_valid;
        sel_ready = in_sel ? out1_ready : out0_ready;
        in_ready  = !sel_valid || sel_ready;
        accept    = in_valid && in_ready;
        acc0      = accept && !in_sel;
        acc1      = accept && in_sel;
        drain0    = out0_valid && out0_ready;
        drain1    = out1_valid && out1_ready;
        stall     = in_valid && !in_ready;
    end

    // Destination 0 slot: a load wins over a drain, giving drain+load throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
        end else if (acc0) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
        end else if (drain0) begin
            out0_valid <= 1'b0;
        end
    end

    // Destination 1 slot: same policy as slot 0, fully independent of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
        end else if (acc1) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
        end else if (drain1) begin
            out1_valid <= 1'b0;
        end
    end

    // A word stalled last cycle must reappear unchanged with in_valid still high.
    always_comb begin
        violation = stall_q &&
                    (!in_valid || (in_data != stall_data_q) || (in_sel != stall_sel_q));
    end

    // Remember the stalled word so the next cycle can be checked against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            stall_sel_q  <= 1'b0;
        end else begin
            stall_q <= stall;
            if (stall) begin
                stall_data_q <= in_data;
                stall_sel_q  <= in_sel;
            end
        end
    end

    // Sticky protocol error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (violation) begin
            proto_err <= 1'b1;
        end
    end

`ifdef ALU_RESULT_DEMUX_CNT_EN
    // Saturating drain counters, one per destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (drain0 && (cnt0 != '1)) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (drain1 && (cnt1 != '1)) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule
